// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pkg : shared types and elaboration helpers for the pipelined   |
// |             Sklansky prefix adder (gp pairs, combine, register plan) |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Logic level after which pipeline register k sits: ceil(k*(levels+2)/stages) - 1.
    function automatic int reg_level(input int k, input int levels, input int stages);
        return ((k * (levels + 2) + stages - 1) / stages) - 1;
    endfunction

    // Stage index whose register follows logic level lvl, or 0 if none does.
    function automatic int stage_at_level(input int lvl, input int levels, input int stages);
        int s;
        s = 0;
        for (int k = 1; k <= stages; k++) begin
            if (reg_level(k, levels, stages) == lvl) s = k;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefix_level.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefix_level : one combinational Sklansky level (span 2^(LEVEL-1))   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module prefix_level
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    localparam int c_span = 1 << (LEVEL - 1);

    // Upper half of each 2*span block absorbs the top bit of the lower half.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i / c_span) % 2) == 1) begin : g_comb
            assign o_gp[i] = gp_combine(i_gp[i], i_gp[(i / c_span) * c_span - 1]);
        end else begin : g_pass
            assign o_gp[i] = i_gp[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefix_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefix_adder_pipe : pipelined Sklansky adder, valid/ready stream,    |
// |                     bubble-collapsing stages. ADDER_SUB_EN adds sub. |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module prefix_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int c_levels = clog2(WIDTH);

    logic [STAGES:1] r_v;
    logic [STAGES:1] w_load;

    // Stage k may load if any stage from k to the output is empty or the output drains.
    for (genvar k = 1; k <= STAGES; k++) begin : g_load
        assign w_load[k] = out_ready | ~(&r_v[STAGES:k]);
    end

    assign in_ready  = rst | w_load[1];
    assign out_valid = r_v[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            if (w_load[1]) r_v[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) begin
                if (w_load[k]) r_v[k] <= r_v[k-1];
            end
        end
    end

    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_unused;

`ifdef ADDER_SUB_EN
    assign w_y   = sub ? ~Y : Y;
    assign w_cin = sub | cin;
`else
    assign w_y   = Y;
    assign w_cin = cin;
`endif

    gp_t [WIDTH-1:0]  w_last_gp;
    logic [WIDTH-1:0] w_last_h;
    logic             w_last_ci;

    for (genvar n = 0; n <= c_levels; n++) begin : g_bound
        localparam int c_stage = stage_at_level(n, c_levels, STAGES);

        gp_t [WIDTH-1:0]  w_gp_d;
        gp_t [WIDTH-1:0]  w_gp_q;
        logic [WIDTH-1:0] w_h_d;
        logic [WIDTH-1:0] w_h_q;
        logic             w_ci_d;
        logic             w_ci_q;

        if (n == 0) begin : g_level0
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i == 0) begin : g_cin
                    assign w_gp_d[i] = {(X[i] & w_y[i]) | ((X[i] | w_y[i]) & w_cin), X[i] | w_y[i]};
                end else begin : g_plain
                    assign w_gp_d[i] = {X[i] & w_y[i], X[i] | w_y[i]};
                end
            end
            assign w_h_d  = X ^ w_y;
            assign w_ci_d = w_cin;
        end else begin : g_prefix
            prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (n)
            ) u_level (
                .i_gp (g_bound[n-1].w_gp_q),
                .o_gp (w_gp_d)
            );
            assign w_h_d  = g_bound[n-1].w_h_q;
            assign w_ci_d = g_bound[n-1].w_ci_q;
        end

        if (c_stage != 0) begin : g_reg
            gp_t [WIDTH-1:0]  r_gp;
            logic [WIDTH-1:0] r_h;
            logic             r_ci;

            always_ff @(posedge clk) begin
                if (w_load[c_stage]) begin
                    r_gp <= w_gp_d;
                    r_h  <= w_h_d;
                    r_ci <= w_ci_d;
                end
            end

            assign w_gp_q = r_gp;
            assign w_h_q  = r_h;
            assign w_ci_q = r_ci;
        end else begin : g_wire
            assign w_gp_q = w_gp_d;
            assign w_h_q  = w_h_d;
            assign w_ci_q = w_ci_d;
        end

        if (n == c_levels) begin : g_last
            assign w_last_gp = w_gp_q;
            assign w_last_h  = w_h_q;
            assign w_last_ci = w_ci_q;
        end
    end

    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign w_c[i] = w_last_gp[i].g;
        assign w_p[i] = w_last_gp[i].p;
    end

    logic [WIDTH-1:0] w_sum;
    assign w_sum = w_last_h ^ {w_c[WIDTH-2:0], w_last_ci};

`ifdef ADDER_SUB_EN
    assign w_unused = ^w_p;
`else
    assign w_unused = ^{w_p, sub};
`endif

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    // The final register is the only one with a data reset, so outputs read 0 after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load[STAGES]) begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH-1];
            r_ovf  <= w_c[WIDTH-2] ^ w_c[WIDTH-1];
        end
    end

    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prefix_adder_pipe : self-checking bench, WIDTH=16/STAGES=3 stream |
// |                        plus WIDTH=6/STAGES=1 directed vectors        |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_prefix_adder_pipe;

    localparam int ST = 3;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
    logic [15:0] X, Y, S;
    logic        in_valid6, in_ready6, out_valid6, cin6, cout6, ovf6;
    logic [5:0]  X6, Y6, S6;

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(16), .STAGES(ST)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout), .ovf(ovf)
    );

    prefix_adder_pipe #(.WIDTH(6), .STAGES(1)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
        .X(X6), .Y(Y6), .cin(cin6), .sub(1'b0),
        .out_valid(out_valid6), .out_ready(1'b1),
        .S(S6), .cout(cout6), .ovf(ovf6)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_emit  = 0;
    res_t exp_q[$];
    vec_t tv  [14];
    vec_t tv6 [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        logic [16:0] t;
        logic [15:0] ye;
        logic        ce;
        res_t        r;
        ye = y;
        ce = ci;
`ifdef ADDER_SUB_EN
        if (sb) begin
            ye = ~y;
            ce = 1'b1;
        end
`else
        if (sb === 1'bx) ce = ci;
`endif
        t      = {1'b0, x} + {1'b0, ye} + {16'b0, ce};
        r.s    = t[15:0];
        r.cout = t[16];
        r.ovf  = (x[15] == ye[15]) && (t[15] != x[15]);
        return r;
    endfunction

    // Scoreboard: pushes accepted beats, pops and compares emitted ones.
    always @(negedge clk) begin : mon
        res_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {14'd0, S, cout, ovf}, {14'd0, e});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(X, Y, cin, sub));
        end
    end

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 32'd0);
        check({name, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int acc;
        int e0;
        int stalls;

        tv[0]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tv[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[3]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[4]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tv[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tv[7]  = '{16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tv[8]  = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[9]  = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tv[10] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[11] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
`ifdef ADDER_SUB_EN
        tv[12] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[13] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
        tv[12] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
        tv[13] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0};
`endif
        tv6[0] = '{16'd63, 16'd1,  1'b0, 1'b0, 16'd0,  1'b1, 1'b0};
        tv6[1] = '{16'd31, 16'd1,  1'b0, 1'b0, 16'd32, 1'b0, 1'b1};
        tv6[2] = '{16'd0,  16'd0,  1'b1, 1'b0, 16'd1,  1'b0, 1'b0};
        tv6[3] = '{16'd32, 16'd32, 1'b0, 1'b0, 16'd0,  1'b1, 1'b1};
        tv6[4] = '{16'd21, 16'd42, 1'b0, 1'b0, 16'd63, 1'b0, 1'b0};
        tv6[5] = '{16'd63, 16'd63, 1'b1, 1'b0, 16'd63, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        X = '0; Y = '0; cin = 1'b0; sub = 1'b0;
        in_valid6 = 1'b0; X6 = '0; Y6 = '0; cin6 = 1'b0;

        // Reset state, with a beat offered during reset that must be dropped.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {14'd0, S, cout, ovf}, 32'd0);
        check("rst_w6", {23'd0, out_valid6, S6, cout6, ovf6}, 32'd0);
        in_valid = 1'b1; X = 16'h0F0F; Y = 16'h0101;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (ST + 1) @(posedge clk);
        #1;
        check("rst_dropped", {31'd0, out_valid}, 32'd0);

        // Directed vectors, one at a time, exact latency.
        for (int i = 0; i < 14; i++) begin
            X = tv[i].x; Y = tv[i].y; cin = tv[i].cin; sub = tv[i].sub; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (ST - 2) begin
                @(posedge clk); #1;
            end
            check("tbl_latency", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
            check("tbl_valid", {31'd0, out_valid}, 32'd1);
            check("tbl_result", {14'd0, S, cout, ovf}, {14'd0, tv[i].s, tv[i].cout, tv[i].ovf});
        end
        sub = 1'b0;
        drain("tbl_drain");

        for (int i = 0; i < 6; i++) begin
            X6 = tv6[i].x[5:0]; Y6 = tv6[i].y[5:0]; cin6 = tv6[i].cin; in_valid6 = 1'b1;
            @(posedge clk); #1;
            in_valid6 = 1'b0;
            check("w6_valid", {31'd0, out_valid6}, 32'd1);
            check("w6_result", {24'd0, S6, cout6, ovf6},
                  {24'd0, tv6[i].s[5:0], tv6[i].cout, tv6[i].ovf});
        end

        // Backpressure: fill, hold 5 cycles, release.
        out_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            X = 16'h0100 + 16'(i); Y = 16'h0F00 + 16'(i * 3); cin = i[0];
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, ST);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {14'd0, S, cout, ovf}, {14'd0, exp_q[0]});
            @(posedge clk); #1;
        end
        e0 = n_emit;
        drain("bp_drain");
        check("bp_emitted", n_emit - e0, ST);

        // Bubble collapse: alternating valid with the output stalled.
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            X = 16'($urandom); Y = 16'($urandom); cin = 1'($urandom);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bubble_accepts", acc, ST);
        check("bubble_in_ready", {31'd0, in_ready}, 32'd0);
        drain("bubble_drain");

        // Reset with three beats in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            X = 16'h1111 * 16'(i + 1); Y = 16'h0101; cin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_outputs", {14'd0, S, cout, ovf}, 32'd0);
        rst = 1'b0; out_ready = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) acc++;
        end
        check("mid_rst_stale", acc, 0);

        // Back-to-back random beats at full rate.
        e0 = n_emit; stalls = 0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            X = 16'($urandom); Y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            if (!in_ready) stalls++;
            @(posedge clk); #1;
        end
        drain("rand_drain");
        check("rand_stalls", stalls, 0);
        check("rand_emitted", n_emit - e0, 10000);

        // Random valid and ready.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            X = 16'($urandom); Y = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        drain("mix_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
